// File: rtl/mc_ctrl_pkg.sv
// rtl/mc_ctrl_pkg.sv - encodings shared by the multi-cycle MIPS controller
package mc_ctrl_pkg;

  // FSM state encoding
  localparam logic [3:0] S_INIT = 4'd0;
  localparam logic [3:0] S_IF   = 4'd1;
  localparam logic [3:0] S_ID   = 4'd2;
  localparam logic [3:0] S_EX_R = 4'd3;
  localparam logic [3:0] S_WB_R = 4'd4;
  localparam logic [3:0] S_EX_I = 4'd5;
  localparam logic [3:0] S_WB_I = 4'd6;
  localparam logic [3:0] S_MA   = 4'd7;
  localparam logic [3:0] S_MW   = 4'd8;
  localparam logic [3:0] S_MR   = 4'd9;
  localparam logic [3:0] S_WB_M = 4'd10;
  localparam logic [3:0] S_BR   = 4'd11;
  localparam logic [3:0] S_J    = 4'd12;

  // opcodes (IR[31:26])
  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_ADDIU = 6'b001001;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_J     = 6'b000010;

  // R-type funct codes (IR[5:0])
  localparam logic [5:0] FN_ADD  = 6'b100000;
  localparam logic [5:0] FN_ADDU = 6'b100001;
  localparam logic [5:0] FN_SUB  = 6'b100010;
  localparam logic [5:0] FN_SUBU = 6'b100011;
  localparam logic [5:0] FN_OR   = 6'b100101;
  localparam logic [5:0] FN_SLT  = 6'b101010;
  localparam logic [5:0] FN_SLTU = 6'b101011;

  // ALUctr codes
  localparam logic [2:0] ALU_ADDU = 3'b000;
  localparam logic [2:0] ALU_ADD  = 3'b001;
  localparam logic [2:0] ALU_OR   = 3'b010;
  localparam logic [2:0] ALU_SUBU = 3'b100;
  localparam logic [2:0] ALU_SUB  = 3'b101;
  localparam logic [2:0] ALU_SLTU = 3'b110;
  localparam logic [2:0] ALU_SLT  = 3'b111;

  // next-PC source codes
  localparam logic [1:0] NPC_SEQ = 2'b00;
  localparam logic [1:0] NPC_BR  = 2'b01;
  localparam logic [1:0] NPC_J   = 2'b10;

endpackage

// File: rtl/mc_control_alu_ctr_enc.sv
// rtl/mc_control_alu_ctr_enc.sv - ALUctr encoder and instruction legality check
module alu_ctr_enc
  import mc_ctrl_pkg::*;
(
  input  logic [5:0] op,
  input  logic [5:0] func,
  input  logic [3:0] state,
  output logic [2:0] alu_ctr,
  output logic       legal
);

  logic [2:0] r_code;
  logic       r_ok;

  // map R-type funct to an ALU code; unknown funct flags the instruction illegal
  always_comb begin
    r_ok   = 1'b1;
    r_code = ALU_ADDU;
    case (func)
      FN_ADDU: r_code = ALU_ADDU;
      FN_ADD:  r_code = ALU_ADD;
      FN_OR:   r_code = ALU_OR;
      FN_SUBU: r_code = ALU_SUBU;
      FN_SUB:  r_code = ALU_SUB;
      FN_SLTU: r_code = ALU_SLTU;
      FN_SLT:  r_code = ALU_SLT;
      default: r_ok   = 1'b0;
    endcase
  end

  // legality of the whole instruction, consumed by the FSM in S_ID
  always_comb begin
    case (op)
      OP_RTYPE:                                        legal = r_ok;
      OP_ORI, OP_ADDIU, OP_LW, OP_SW, OP_BEQ, OP_J:    legal = 1'b1;
      default:                                         legal = 1'b0;
    endcase
  end

  // ALU operation is only non-zero in states that actually use the ALU
  always_comb begin
    alu_ctr = ALU_ADDU;
    case (state)
      S_EX_R:  alu_ctr = r_code;
      S_EX_I:  alu_ctr = (op == OP_ORI) ? ALU_OR : ALU_ADDU;
      S_MA:    alu_ctr = ALU_ADDU;
      S_BR:    alu_ctr = ALU_SUBU;
      default: alu_ctr = ALU_ADDU;
    endcase
  end

endmodule

// File: rtl/mc_control.sv
// rtl/mc_control.sv - multi-cycle MIPS main controller FSM
module mc_control
  import mc_ctrl_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic [5:0] op,
  input  logic [5:0] func,
  input  logic       Zero,
  input  logic       Overflow,
  output logic       PCWr,
  output logic [1:0] nPCsel,
  output logic       IRWr,
  output logic       RegWr,
  output logic       RegDst,
  output logic       MemWr,
  output logic       MemtoReg,
  output logic       ALUSrc,
  output logic       ExtOp,
  output logic [2:0] ALUctr,
  output logic       InstrDone,
  output logic       IllegalOp,
  output logic       OvTrap
);

  logic [3:0] state;
  logic [3:0] state_nxt;
  logic       ov_q;
  logic       legal;
  logic       is_addsub;

  alu_ctr_enc u_alu_ctr_enc (
    .op      (op),
    .func    (func),
    .state   (state),
    .alu_ctr (ALUctr),
    .legal   (legal)
  );

  // only the trapping add/sub forms may discard their result on overflow
  assign is_addsub = (func == FN_ADD) || (func == FN_SUB);

  // state register plus overflow flag latched at the end of R-type execute
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_INIT;
      ov_q  <= 1'b0;
    end else begin
      state <= state_nxt;
      if (state == S_EX_R) ov_q <= Overflow & is_addsub;
    end
  end

  // next-state: dispatch in S_ID, every final state returns to fetch
  always_comb begin
    state_nxt = S_IF;
    case (state)
      S_IF:   state_nxt = S_ID;
      S_ID: begin
        if (!legal) state_nxt = S_IF;
        else begin
          case (op)
            OP_RTYPE:         state_nxt = S_EX_R;
            OP_ORI, OP_ADDIU: state_nxt = S_EX_I;
            OP_LW, OP_SW:     state_nxt = S_MA;
            OP_BEQ:           state_nxt = S_BR;
            OP_J:             state_nxt = S_J;
            default:          state_nxt = S_IF;
          endcase
        end
      end
      S_EX_R: state_nxt = S_WB_R;
      S_EX_I: state_nxt = S_WB_I;
      S_MA:   state_nxt = (op == OP_LW) ? S_MR : S_MW;
      S_MR:   state_nxt = S_WB_M;
      default: state_nxt = S_IF;
    endcase
  end

  // Moore outputs; S_INIT (held during reset) leaves every enable at 0
  always_comb begin
    PCWr      = 1'b0;
    nPCsel    = NPC_SEQ;
    IRWr      = 1'b0;
    RegWr     = 1'b0;
    RegDst    = 1'b0;
    MemWr     = 1'b0;
    MemtoReg  = 1'b0;
    ALUSrc    = 1'b0;
    ExtOp     = 1'b0;
    InstrDone = 1'b0;
    IllegalOp = 1'b0;
    OvTrap    = 1'b0;
    case (state)
      S_IF: begin
        IRWr = 1'b1;
        PCWr = 1'b1;
      end
      S_ID:   IllegalOp = ~legal;
      S_WB_R: begin
        RegDst    = 1'b1;
        RegWr     = ~ov_q;
        OvTrap    = ov_q;
        InstrDone = 1'b1;
      end
      S_EX_I: begin
        ALUSrc = 1'b1;
        ExtOp  = (op == OP_ADDIU);
      end
      S_WB_I: begin
        RegWr     = 1'b1;
        InstrDone = 1'b1;
      end
      S_MA: begin
        ALUSrc = 1'b1;
        ExtOp  = 1'b1;
      end
      S_MW: begin
        MemWr     = 1'b1;
        InstrDone = 1'b1;
      end
      S_WB_M: begin
        MemtoReg  = 1'b1;
        RegWr     = 1'b1;
        InstrDone = 1'b1;
      end
      S_BR: begin
        nPCsel    = NPC_BR;
        PCWr      = Zero;
        InstrDone = 1'b1;
      end
      S_J: begin
        nPCsel    = NPC_J;
        PCWr      = 1'b1;
        InstrDone = 1'b1;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_mc_control.sv
// tb/tb_mc_control.sv - randomized self-checking bench for mc_control
module tb_mc_control;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [5:0] op;
  logic [5:0] func;
  logic       Zero;
  logic       Overflow;
  logic       PCWr;
  logic [1:0] nPCsel;
  logic       IRWr;
  logic       RegWr;
  logic       RegDst;
  logic       MemWr;
  logic       MemtoReg;
  logic       ALUSrc;
  logic       ExtOp;
  logic [2:0] ALUctr;
  logic       InstrDone;
  logic       IllegalOp;
  logic       OvTrap;

  int total = 0;
  int bad   = 0;

  logic [15:0] exp_tr [0:4];
  int          exp_len;

  logic [5:0] op_list   [0:6] = '{6'h00, 6'h0d, 6'h09, 6'h23, 6'h2b, 6'h04, 6'h02};
  logic [5:0] func_list [0:6] = '{6'h20, 6'h21, 6'h22, 6'h23, 6'h25, 6'h2a, 6'h2b};

  always #5 clk = ~clk;

  mc_control dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .op        (op),
    .func      (func),
    .Zero      (Zero),
    .Overflow  (Overflow),
    .PCWr      (PCWr),
    .nPCsel    (nPCsel),
    .IRWr      (IRWr),
    .RegWr     (RegWr),
    .RegDst    (RegDst),
    .MemWr     (MemWr),
    .MemtoReg  (MemtoReg),
    .ALUSrc    (ALUSrc),
    .ExtOp     (ExtOp),
    .ALUctr    (ALUctr),
    .InstrDone (InstrDone),
    .IllegalOp (IllegalOp),
    .OvTrap    (OvTrap)
  );

  // observed output vector, same field order as ev()
  function automatic logic [15:0] obs();
    return {PCWr, nPCsel, IRWr, RegWr, RegDst, MemWr, MemtoReg,
            ALUSrc, ExtOp, ALUctr, InstrDone, IllegalOp, OvTrap};
  endfunction

  function automatic logic [15:0] ev(input logic pcwr, input logic [1:0] npc,
      input logic irwr, input logic regwr, input logic regdst, input logic memwr,
      input logic memtoreg, input logic alusrc, input logic extop,
      input logic [2:0] alu, input logic done, input logic ill, input logic ovt);
    return {pcwr, npc, irwr, regwr, regdst, memwr, memtoreg,
            alusrc, extop, alu, done, ill, ovt};
  endfunction

  task automatic check_eq(input string tag, input logic [15:0] got, input logic [15:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s got=%04h exp=%04h", tag, got, want);
    end
  endtask

  // reference: expected per-cycle output trace for one instruction
  task automatic build(input logic [5:0] o, input logic [5:0] f, input logic z, input logic v);
    logic [2:0] rc;
    logic       rok;
    logic       trap;
    rok = 1'b1;
    case (f)
      6'h21: rc = 3'b000;
      6'h20: rc = 3'b001;
      6'h25: rc = 3'b010;
      6'h23: rc = 3'b100;
      6'h22: rc = 3'b101;
      6'h2b: rc = 3'b110;
      6'h2a: rc = 3'b111;
      default: begin rc = 3'b000; rok = 1'b0; end
    endcase
    for (int i = 0; i < 5; i++) exp_tr[i] = 16'h0;
    exp_tr[0] = ev(1, 2'b00, 1, 0, 0, 0, 0, 0, 0, 3'b000, 0, 0, 0);
    if (o == 6'h00 && rok) begin
      trap = v && (f == 6'h20 || f == 6'h22);
      exp_tr[2] = ev(0, 2'b00, 0, 0, 0, 0, 0, 0, 0, rc, 0, 0, 0);
      exp_tr[3] = ev(0, 2'b00, 0, !trap, 1, 0, 0, 0, 0, 3'b000, 1, 0, trap);
      exp_len = 4;
    end else if (o == 6'h0d || o == 6'h09) begin
      exp_tr[2] = ev(0, 2'b00, 0, 0, 0, 0, 0, 1, o == 6'h09,
                     (o == 6'h0d) ? 3'b010 : 3'b000, 0, 0, 0);
      exp_tr[3] = ev(0, 2'b00, 0, 1, 0, 0, 0, 0, 0, 3'b000, 1, 0, 0);
      exp_len = 4;
    end else if (o == 6'h23) begin
      exp_tr[2] = ev(0, 2'b00, 0, 0, 0, 0, 0, 1, 1, 3'b000, 0, 0, 0);
      exp_tr[4] = ev(0, 2'b00, 0, 1, 0, 0, 1, 0, 0, 3'b000, 1, 0, 0);
      exp_len = 5;
    end else if (o == 6'h2b) begin
      exp_tr[2] = ev(0, 2'b00, 0, 0, 0, 0, 0, 1, 1, 3'b000, 0, 0, 0);
      exp_tr[3] = ev(0, 2'b00, 0, 0, 0, 1, 0, 0, 0, 3'b000, 1, 0, 0);
      exp_len = 4;
    end else if (o == 6'h04) begin
      exp_tr[2] = ev(z, 2'b01, 0, 0, 0, 0, 0, 0, 0, 3'b100, 1, 0, 0);
      exp_len = 3;
    end else if (o == 6'h02) begin
      exp_tr[2] = ev(1, 2'b10, 0, 0, 0, 0, 0, 0, 0, 3'b000, 1, 0, 0);
      exp_len = 3;
    end else begin
      exp_tr[1] = ev(0, 2'b00, 0, 0, 0, 0, 0, 0, 0, 3'b000, 0, 1, 0);
      exp_len = 2;
    end
  endtask

  // entered just after the negedge of an IF cycle; leaves at the next IF negedge
  task automatic run_instr(input logic [5:0] o, input logic [5:0] f, input logic z,
                           input logic v, input int abort_at);
    op = o; func = f; Zero = z; Overflow = v;
    build(o, f, z, v);
    for (int k = 0; k < exp_len; k++) begin
      if (k > 0) @(negedge clk);
      #1;
      check_eq($sformatf("op%02h_f%02h_z%0d_v%0d_c%0d", o, f, z, v, k), obs(), exp_tr[k]);
      if (k == abort_at) begin
        #1 rst_n = 1'b0;
        #1 check_eq($sformatf("abort_async_c%0d", k), obs(), 16'h0);
        @(negedge clk);
        #1 check_eq("abort_held", obs(), 16'h0);
        @(negedge clk);
        rst_n = 1'b1;
        #1 check_eq("abort_release_init", obs(), 16'h0);
        @(negedge clk);
        return;
      end
    end
    @(negedge clk);
  endtask

  initial begin
    logic [5:0] o;
    logic [5:0] f;
    rst_n = 1'b0; op = 6'h23; func = 6'h20; Zero = 1'b1; Overflow = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      op = 6'($urandom); func = 6'($urandom);
      #1 check_eq($sformatf("reset_zero_%0d", i), obs(), 16'h0);
    end
    @(negedge clk);
    rst_n = 1'b1;
    #1 check_eq("release_init", obs(), 16'h0);
    @(negedge clk);

    run_instr(6'h00, 6'h20, 1'b0, 1'b0, -1);
    run_instr(6'h00, 6'h20, 1'b0, 1'b1, -1);
    run_instr(6'h00, 6'h22, 1'b1, 1'b1, -1);
    run_instr(6'h00, 6'h21, 1'b0, 1'b1, -1);
    run_instr(6'h23, 6'h00, 1'b0, 1'b0, -1);
    run_instr(6'h2b, 6'h00, 1'b0, 1'b0, -1);
    run_instr(6'h04, 6'h00, 1'b1, 1'b0, -1);
    run_instr(6'h04, 6'h00, 1'b0, 1'b0, -1);
    run_instr(6'h02, 6'h00, 1'b0, 1'b0, -1);
    run_instr(6'h0d, 6'h00, 1'b0, 1'b0, -1);
    run_instr(6'h09, 6'h00, 1'b0, 1'b0, -1);
    run_instr(6'h3f, 6'h20, 1'b0, 1'b0, -1);
    run_instr(6'h00, 6'h24, 1'b0, 1'b0, -1);
    run_instr(6'h23, 6'h00, 1'b0, 1'b0, 3);
    run_instr(6'h2b, 6'h00, 1'b0, 1'b0, 2);

    for (int n = 0; n < 80; n++) begin
      if ($urandom_range(0, 7) == 0) o = 6'($urandom);
      else o = op_list[$urandom_range(0, 6)];
      if ($urandom_range(0, 3) == 0) f = 6'($urandom);
      else f = func_list[$urandom_range(0, 6)];
      run_instr(o, f, 1'($urandom), 1'($urandom), -1);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
